// File: rtl/jtframe_dump_pkg.sv
// jtframe_dump_pkg: shared channel state type and defaults for the frame-windowed dump trigger.
package jtframe_dump_pkg;

    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_WAIT = 2'd1,
        CH_ON   = 2'd2,
        CH_DONE = 2'd3
    } chan_state_t;

    localparam int DEF_CH  = 4;
    localparam int DEF_FW  = 32;
    // A window length of zero keeps the channel open forever
    localparam int LEN_INF = 0;

endpackage

// File: rtl/jtframe_dump_chan.sv
// jtframe_dump_chan: one probe channel; waits for its start frame, stays on for len frame
// ticks (or forever when len is zero), then reports done until reset or disarm.
module jtframe_dump_chan
    import jtframe_dump_pkg::*;
#(
    parameter int FW = DEF_FW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [FW-1:0] frame_cnt,
    input  logic          fall,
    input  logic          armed,
    input  logic          stop,
    input  logic [FW-1:0] start,
    input  logic [FW-1:0] len,
    output logic          dump_en,
    output logic          done
);

    chan_state_t   state;
    chan_state_t   state_nxt;
    logic [FW-1:0] elapsed;
    logic [FW-1:0] elapsed_nxt;
    logic          last_frame;

    // The frame tick that brings elapsed up to len closes the window; LEN_INF never closes it
    always_comb begin
        last_frame = (len != FW'(LEN_INF)) && ((elapsed + FW'(1)) == len);
    end

    // Next state: stop beats everything, then disarm, then the normal window progression
    always_comb begin
        state_nxt   = state;
        elapsed_nxt = elapsed;
        if (stop && (state == CH_WAIT || state == CH_ON)) begin
            state_nxt = CH_DONE;
        end else if (!armed) begin
            state_nxt = CH_IDLE;
        end else begin
            case (state)
                CH_IDLE: state_nxt = CH_WAIT;
                CH_WAIT: begin
                    if (frame_cnt == start) begin
                        state_nxt   = CH_ON;
                        elapsed_nxt = '0;
                    end
                end
                CH_ON: begin
                    if (fall) begin
                        if (last_frame) begin
                            state_nxt = CH_DONE;
                        end else if (elapsed != '1) begin
                            elapsed_nxt = elapsed + FW'(1);
                        end
                    end
                end
                CH_DONE: state_nxt = CH_DONE;
                default: state_nxt = CH_IDLE;
            endcase
        end
    end

    // State and elapsed registers; outputs are flops decoded from the next state so they move with it
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CH_IDLE;
            elapsed <= '0;
            dump_en <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            elapsed <= elapsed_nxt;
            dump_en <= (state_nxt == CH_ON);
            done    <= (state_nxt == CH_DONE);
        end
    end

endmodule

// File: rtl/jtframe_dump_trig.sv
// jtframe_dump_trig: counts frames from VS and drives per-channel dump windows.
// Optional feature macro JTFRAME_DUMP_LOADROM_EN: arm on the end of ROM download and
// disarm when a new download starts; without it the trigger arms right after reset.
module jtframe_dump_trig
    import jtframe_dump_pkg::*;
#(
    parameter int CH = DEF_CH,
    parameter int FW = DEF_FW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vs,
    input  logic             downloading,
    input  logic [CH*FW-1:0] start,
    input  logic [CH*FW-1:0] len,
    input  logic             stop,
    output logic [FW-1:0]    frame_cnt,
    output logic             armed,
    output logic [CH-1:0]    dump_en,
    output logic [CH-1:0]    done
);

    logic vs_l;
    logic fall;
    logic frame_tick;
    logic stop_l;
    logic disarm;

    // Frame strobe: VS seen high last cycle and low now
    always_comb begin
        fall = vs_l & ~vs;
    end

    // VS history plus copies of the strobe and stop delayed to line up with the updated frame_cnt
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_l       <= 1'b0;
            frame_tick <= 1'b0;
            stop_l     <= 1'b0;
        end else begin
            vs_l       <= vs;
            frame_tick <= fall;
            stop_l     <= stop;
        end
    end

`ifdef JTFRAME_DUMP_LOADROM_EN
    logic dl_l;
    logic dl_fall;
    logic dl_rise;

    // Download edges; a rising edge only matters while armed
    always_comb begin
        dl_fall = dl_l & ~downloading;
        dl_rise = ~dl_l & downloading;
        disarm  = armed & dl_rise;
    end

    // Arm once a download finishes, drop back out when the next one begins
    always_ff @(posedge clk) begin
        if (rst) begin
            dl_l  <= 1'b0;
            armed <= 1'b0;
        end else begin
            dl_l <= downloading;
            if (disarm) begin
                armed <= 1'b0;
            end else if (dl_fall) begin
                armed <= 1'b1;
            end
        end
    end
`else
    logic unused_dl;

    // Download flag has no role here; nothing ever disarms outside reset
    always_comb begin
        unused_dl = downloading;
        disarm    = 1'b0;
    end

    // Arm on the first cycle after reset is released
    always_ff @(posedge clk) begin
        if (rst) begin
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
        end
    end
`endif

    // Frame counter: held at zero while unarmed, counts VS falls and sticks at all-ones
    always_ff @(posedge clk) begin
        if (rst || !armed || disarm) begin
            frame_cnt <= '0;
        end else if (fall && (frame_cnt != '1)) begin
            frame_cnt <= frame_cnt + FW'(1);
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_chan
        jtframe_dump_chan #(
            .FW(FW)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .frame_cnt(frame_cnt),
            .fall     (frame_tick),
            .armed    (armed),
            .stop     (stop_l),
            .start    (start[i*FW +: FW]),
            .len      (len[i*FW +: FW]),
            .dump_en  (dump_en[i]),
            .done     (done[i])
        );
    end

endmodule
